ram_stream_reader: RTL and testbench

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

---
 rtl/ram_stream_pkg.sv | 13 +
 rtl/stream_skid_fifo.sv | 48 ++++
 rtl/ram_stream_reader.sv | 156 +++++++++++++++
 tb/tb_ram_stream_reader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_stream_pkg.sv
// Shared types and default widths for the RAM stream reader.
package ram_stream_pkg;

    localparam int DEF_RAM_WIDTH = 16;
    localparam int DEF_ADDR_LINE = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry buffer between the RAM read port and the output stream.
// The caller guarantees it never pushes into a full buffer nor pops an empty one.
module stream_skid_fifo #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_last,
    input  logic             pop,
    output logic [1:0]       occupancy,
    output logic [WIDTH-1:0] head_data,
    output logic             head_last
);

    logic [WIDTH:0] slot [2];
    logic           wr_ptr;
    logic           rd_ptr;
    logic [1:0]     count;

    // Pointer and occupancy bookkeeping; reset flushes the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage slots carry the word plus its end-of-burst flag.
    always_ff @(posedge clk) begin
        if (push) slot[wr_ptr] <= {push_last, push_data};
    end

    assign occupancy = count;
    assign head_data = slot[rd_ptr][WIDTH-1:0];
    assign head_last = slot[rd_ptr][WIDTH];

endmodule

// File: rtl/ram_stream_reader.sv
// Streams a burst of words from a synchronous-read RAM onto a valid/ready port.
// Optional feature: define RAM_STREAM_REVERSE_EN to add the 'reverse' input,
// which makes the burst read descending addresses.
module ram_stream_reader
    import ram_stream_pkg::*;
#(
    parameter int RAM_WIDTH = DEF_RAM_WIDTH,
    parameter int ADDR_LINE = DEF_ADDR_LINE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_LINE-1:0] base_addr,
    input  logic [ADDR_LINE:0]   word_cnt,
`ifdef RAM_STREAM_REVERSE_EN
    input  logic                 reverse,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 ram_rd_en,
    output logic [ADDR_LINE-1:0] ram_rd_addr,
    input  logic [RAM_WIDTH-1:0] ram_rd_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [RAM_WIDTH-1:0] m_data,
    output logic                 m_last
);

    // state    | meaning
    // ST_IDLE  | waiting for start; the first read is issued in the accepting cycle
    // ST_RUN   | issuing reads while the buffer has room
    // ST_DRAIN | all reads issued, waiting for the last word to handshake

    localparam logic [ADDR_LINE:0]   CNT_ZERO = '0;
    localparam logic [ADDR_LINE:0]   CNT_ONE  = {{ADDR_LINE{1'b0}}, 1'b1};
    localparam logic [ADDR_LINE-1:0] ADDR_ONE = {{(ADDR_LINE-1){1'b0}}, 1'b1};

    state_t                 state;
    state_t                 state_nxt;
    logic [ADDR_LINE-1:0]   rd_addr;
    logic [ADDR_LINE:0]     reads_left;
    logic                   inflight;
    logic                   inflight_last;
    logic [1:0]             occ;
    logic [RAM_WIDTH-1:0]   head_data;
    logic                   head_last;
    logic                   pop;
    logic                   room;
    logic                   start_ok;
    logic                   issue;
    logic                   issue_last;
    logic [ADDR_LINE-1:0]   issue_addr;
    logic [ADDR_LINE-1:0]   step_addr;
    logic [2:0]             outstanding;
    logic                   dir_rev;

`ifdef RAM_STREAM_REVERSE_EN
    logic reverse_q;

    // Direction is latched with the burst so it cannot change mid-stream.
    always_ff @(posedge clk) begin
        if (rst) reverse_q <= 1'b0;
        else if (start_ok) reverse_q <= reverse;
    end

    assign dir_rev = (state == ST_IDLE) ? reverse : reverse_q;
`else
    assign dir_rev = 1'b0;
`endif

    // Words already owned by the reader: buffered plus the read in flight.
    assign outstanding = {1'b0, occ} + {2'b00, inflight};
    assign m_valid     = (occ != 2'd0);
    assign pop         = m_valid & m_ready;
    assign room        = (outstanding - {2'b00, pop}) < 3'd2;
    // The done cycle still counts as busy, so a start landing there is ignored.
    assign start_ok    = (state == ST_IDLE) & start & ~done & ~rst;
    assign step_addr   = dir_rev ? (issue_addr - ADDR_ONE) : (issue_addr + ADDR_ONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and read-issue decisions.
    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        issue_last = 1'b0;
        issue_addr = rd_addr;
        case (state)
            ST_IDLE: begin
                if (start_ok && (word_cnt != CNT_ZERO)) begin
                    issue      = 1'b1;
                    issue_addr = base_addr;
                    issue_last = (word_cnt == CNT_ONE);
                    state_nxt  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (reads_left == CNT_ZERO) begin
                    state_nxt = ST_DRAIN;
                end else if (room) begin
                    issue      = 1'b1;
                    issue_last = (reads_left == CNT_ONE);
                    if (reads_left == CNT_ONE) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && m_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Address/count tracking, in-flight read tracking and the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr       <= '0;
            reads_left    <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue_last;
            if (issue) rd_addr <= step_addr;
            if (issue) begin
                if (state == ST_IDLE) reads_left <= word_cnt - CNT_ONE;
                else                  reads_left <= reads_left - CNT_ONE;
            end
            done <= (start_ok && (word_cnt == CNT_ZERO)) ||
                    ((state != ST_IDLE) && pop && m_last);
        end
    end

    stream_skid_fifo #(.WIDTH(RAM_WIDTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (ram_rd_data),
        .push_last (inflight_last),
        .pop       (pop),
        .occupancy (occ),
        .head_data (head_data),
        .head_last (head_last)
    );

    assign busy        = (state != ST_IDLE) | done;
    assign ram_rd_en   = issue;
    assign ram_rd_addr = issue ? issue_addr : '0;
    assign m_data      = m_valid ? head_data : '0;
    assign m_last      = m_valid & head_last;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: behavioural RAM, expected address/data queues
// built from the burst parameters, and per-cycle protocol checks.
module tb_ram_stream_reader;

    localparam int W = 16;
    localparam int A = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [A-1:0] base_addr;
    logic [A:0]   word_cnt;
`ifdef RAM_STREAM_REVERSE_EN
    logic         reverse;
`endif
    logic         busy;
    logic         done;
    logic         ram_rd_en;
    logic [A-1:0] ram_rd_addr;
    logic [W-1:0] ram_rd_data = '0;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic         m_last;

    always #5 clk = ~clk;

    ram_stream_reader #(.RAM_WIDTH(W), .ADDR_LINE(A)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .word_cnt    (word_cnt),
`ifdef RAM_STREAM_REVERSE_EN
        .reverse     (reverse),
`endif
        .busy        (busy),
        .done        (done),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last)
    );

    logic [W-1:0] mem [256];

    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [A-1:0] exp_addr [$];
    logic [W-1:0] exp_data [$];
    int           n_issued = 0;
    int           n_popped = 0;
    bit           prev_stall = 0;
    logic [W-1:0] prev_data;
    logic         prev_last;

    // Per-cycle protocol monitor.
    always @(negedge clk) begin
        if (rst) begin
            n_issued   = 0;
            n_popped   = 0;
            prev_stall = 0;
        end else begin
            if (ram_rd_en) begin
                check("rd_room", 32'((n_issued - n_popped - ((m_valid && m_ready) ? 1 : 0)) < 2), 32'd1);
                check("rd_expected", 32'(exp_addr.size() > 0), 32'd1);
                if (exp_addr.size() > 0) check("rd_addr", 32'(ram_rd_addr), 32'(exp_addr.pop_front()));
                n_issued++;
            end
            if (prev_stall) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", 32'(m_data), 32'(prev_data));
                check("hold_last", 32'(m_last), 32'(prev_last));
            end
            if (m_valid && m_ready) begin
                check("hs_expected", 32'(exp_data.size() > 0), 32'd1);
                if (exp_data.size() > 0) begin
                    check("hs_data", 32'(m_data), 32'(exp_data.pop_front()));
                    check("hs_last", 32'(m_last), 32'(exp_data.size() == 0));
                end
                n_popped++;
            end
            if (!m_valid) begin
                check("idle_data", 32'(m_data), 32'd0);
                check("idle_last", 32'(m_last), 32'd0);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic build_expect(input logic [A-1:0] base, input int cnt, input bit rev);
        logic [A-1:0] a;
        exp_addr.delete();
        exp_data.delete();
        for (int k = 0; k < cnt; k++) begin
            a = rev ? (base - A'(k)) : (base + A'(k));
            exp_addr.push_back(a);
            exp_data.push_back(mem[a]);
        end
    endtask

    task automatic run_burst(input logic [A-1:0] base, input int cnt, input bit rev, input bit rand_ready);
        int first_v;
        int done_at;
        int last_hs;
        int n_done;
        int n_hs;
        build_expect(base, cnt, rev);
        @(posedge clk) #1;
        start     = 1'b1;
        base_addr = base;
        word_cnt  = (A+1)'(cnt);
`ifdef RAM_STREAM_REVERSE_EN
        reverse   = rev;
`endif
        m_ready   = 1'b1;
        @(negedge clk);
        check("idle_before_start", 32'(busy), 32'd0);
        first_v = -1; done_at = -1; last_hs = -1; n_done = 0; n_hs = 0;
        for (int rel = 1; rel <= cnt * 8 + 40; rel++) begin
            @(posedge clk) #1;
            start   = 1'b0;
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (rel == 1) check("busy_after_start", 32'(busy), 32'd1);
            if (m_valid && first_v < 0) first_v = rel;
            if (m_valid && m_ready) begin n_hs++; last_hs = rel; end
            if (done) begin n_done++; if (done_at < 0) done_at = rel; end
            if (done_at >= 0 && rel == done_at) check("busy_at_done", 32'(busy), 32'd1);
            if (done_at >= 0 && rel == done_at + 1) begin
                check("busy_fall", 32'(busy), 32'd0);
                break;
            end
        end
        check("done_seen", 32'(done_at >= 0), 32'd1);
        check("done_count", 32'(n_done), 32'd1);
        check("hs_count", 32'(n_hs), 32'(cnt));
        if (cnt > 0) begin
            check("first_valid_lat", 32'(first_v), 32'd2);
            check("done_lat", 32'(done_at), 32'(last_hs + 1));
            if (!rand_ready) check("full_rate", 32'(last_hs), 32'(cnt + 1));
        end else begin
            check("zero_done_lat", 32'(done_at), 32'd1);
            check("zero_no_valid", 32'(first_v), 32'hFFFF_FFFF);
        end
        check("data_q_empty", 32'(exp_data.size()), 32'd0);
        check("addr_q_empty", 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_rd_en"}, 32'(ram_rd_en), 32'd0);
        check({tag, "_rd_addr"}, 32'(ram_rd_addr), 32'd0);
        check({tag, "_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_last"}, 32'(m_last), 32'd0);
        check({tag, "_data"}, 32'(m_data), 32'd0);
    endtask

    initial begin
        int hs;
        int nd;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        word_cnt  = '0;
        m_ready   = 1'b0;
`ifdef RAM_STREAM_REVERSE_EN
        reverse   = 1'b0;
`endif
        for (int i = 0; i < 256; i++) mem[i] = W'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk) #1;
        rst = 1'b0;

        run_burst(8'h10, 4, 1'b0, 1'b0);
        run_burst(8'hFE, 4, 1'b0, 1'b0);

        for (int i = 0; i < 256; i++) mem[i] = W'($urandom);
        run_burst(A'($urandom), 8, 1'b0, 1'b1);
        run_burst(A'($urandom), 0, 1'b0, 1'b0);

        // Reset in the middle of an 8-word burst, after three words.
        build_expect(8'h40, 8, 1'b0);
        @(posedge clk) #1;
        start     = 1'b1;
        base_addr = 8'h40;
        word_cnt  = 9'd8;
        m_ready   = 1'b1;
        hs = 0;
        for (int c = 0; c < 40 && hs < 3; c++) begin
            @(posedge clk) #1;
            start = 1'b0;
            @(negedge clk);
            if (m_valid && m_ready) hs++;
        end
        check("rst_hs_reached", 32'(hs), 32'd3);
        @(posedge clk) #1;
        rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        @(negedge clk);
        check_zero_outputs("midrst");
        nd = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("midrst_no_done", 32'(nd), 32'd0);
        run_burst(A'($urandom), 2, 1'b0, 1'b0);

`ifdef RAM_STREAM_REVERSE_EN
        run_burst(8'h01, 3, 1'b1, 1'b0);
        run_burst(A'($urandom), 6, 1'b1, 1'b1);
`endif

        for (int t = 0; t < 4; t++) begin
`ifdef RAM_STREAM_REVERSE_EN
            run_burst(A'($urandom), int'($urandom_range(1, 20)), 1'($urandom_range(0, 1)), 1'b1);
`else
            run_burst(A'($urandom), int'($urandom_range(1, 20)), 1'b0, 1'b1);
`endif
        end

        run_burst(A'($urandom), 256, 1'b0, 1'b0);
        run_burst(8'hFF, 1, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
